// File: rtl/rf_2p_banked_pkg.sv
// Shared types and width helpers for the banked two-port register file.
// Bank FSM encoding and address-split derivation live here.
package rf_2p_banked_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        RET    = 2'd1,
        WAKE   = 2'd2
    } bank_state_t;

    localparam int DEF_BITS        = 32;
    localparam int DEF_DEPTH       = 256;
    localparam int DEF_NBANKS      = 4;
    localparam int DEF_IDLE_CYCLES = 16;
    localparam int DEF_WAKE_CYCLES = 2;
    localparam int DEF_CNT_W       = 32;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int bank_w(input int nbanks);
        return $clog2(nbanks);
    endfunction

    function automatic int row_w(input int depth, input int nbanks);
        return $clog2(depth) - $clog2(nbanks);
    endfunction

    // Select width never collapses to zero so single-bank builds stay legal.
    function automatic int sel_w(input int nbanks);
        return (nbanks > 1) ? $clog2(nbanks) : 1;
    endfunction

endpackage

// File: rtl/rf_2p_bank_ret.sv
// One bank of the register file: array slice, retention FSM,
// idle/wake counters and local ready.
module rf_2p_bank_ret
    import rf_2p_banked_pkg::*;
#(
    parameter int BITS        = DEF_BITS,
    parameter int ROWS        = 64,
    parameter int ROW_W       = 6,
    parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
    parameter int WAKE_CYCLES = DEF_WAKE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_req,
    input  logic             wr_req,
    input  logic [ROW_W-1:0] rd_row,
    input  logic [ROW_W-1:0] wr_row,
    input  logic [BITS-1:0]  wr_data,
    output logic [BITS-1:0]  rd_data,
    output logic             rdy,
    output logic             ret_n
);

    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam int WW = $clog2(WAKE_CYCLES + 1);

    bank_state_t   state, state_nx;
    logic [IW-1:0] idle_q, idle_nx;
    logic [WW-1:0] wake_q, wake_nx;
    logic          req;
    logic [BITS-1:0] mem [ROWS];

    assign req     = rd_req | wr_req;
    assign rd_data = mem[rd_row];

    // State and counter registers; array contents are not touched by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ACTIVE;
            idle_q <= '0;
            wake_q <= '0;
        end else begin
            state  <= state_nx;
            idle_q <= idle_nx;
            wake_q <= wake_nx;
        end
    end

    // Retention FSM: idle timeout into RET, request-driven wake back out.
    // The request cycle in RET counts as the first wake cycle.
    always_comb begin
        state_nx = state;
        idle_nx  = idle_q;
        wake_nx  = wake_q;
        rdy      = 1'b0;
        ret_n    = 1'b1;
        unique case (state)
            ACTIVE: begin
                rdy = 1'b1;
                if (req) begin
                    idle_nx = '0;
                end else if (idle_q == IW'(IDLE_CYCLES - 1)) begin
                    state_nx = RET;
                    idle_nx  = '0;
                end else begin
                    idle_nx = idle_q + IW'(1);
                end
            end
            RET: begin
                ret_n = 1'b0;
                if (req) begin
                    if (WAKE_CYCLES == 1) begin
                        state_nx = ACTIVE;
                    end else begin
                        state_nx = WAKE;
                        wake_nx  = WW'(1);
                    end
                end
            end
            WAKE: begin
                if (wake_q == WW'(WAKE_CYCLES - 1)) begin
                    state_nx = ACTIVE;
                    wake_nx  = '0;
                    idle_nx  = '0;
                end else begin
                    wake_nx = wake_q + WW'(1);
                end
            end
            default: state_nx = ACTIVE;
        endcase
    end

    // Array write, only when the bank is awake and the write is accepted.
    always_ff @(posedge clk) begin
        if (wr_req && state == ACTIVE) begin
            mem[wr_row] <= wr_data;
        end
    end

endmodule

// File: rtl/rf_2p_banked_ret.sv
// Banked two-port register file with per-bank retention.
// Top level: address decode, write-first bypass, QA register, statistics.
module rf_2p_banked_ret
    import rf_2p_banked_pkg::*;
#(
    parameter int BITS        = DEF_BITS,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int NBANKS      = DEF_NBANKS,
    parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
    parameter int WAKE_CYCLES = DEF_WAKE_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     CENA,
    input  logic [$clog2(DEPTH)-1:0] AA,
    output logic [BITS-1:0]          QA,
    output logic                     RDYA,
    input  logic                     CENB,
    input  logic [$clog2(DEPTH)-1:0] AB,
    input  logic [BITS-1:0]          DB,
    output logic                     RDYB,
    output logic [NBANKS-1:0]        ret_n,
    output logic [CNT_W-1:0]         rd_cnt,
    output logic [CNT_W-1:0]         wr_cnt,
    output logic [CNT_W-1:0]         ret_cnt
);

    localparam int AW   = addr_w(DEPTH);
    localparam int BW   = bank_w(NBANKS);
    localparam int RW   = row_w(DEPTH, NBANKS);
    localparam int SW   = sel_w(NBANKS);
    localparam int ROWS = DEPTH / NBANKS;

    logic [SW-1:0]     rd_bank, wr_bank;
    logic [RW-1:0]     rd_row, wr_row;
    logic              a_go, b_go;
    logic [NBANKS-1:0] rd_req, wr_req, bank_rdy;
    logic [BITS-1:0]   rdata [NBANKS];

    assign rd_row = AA[RW-1:0];
    assign wr_row = AB[RW-1:0];

    if (NBANKS > 1) begin : g_sel
        assign rd_bank = AA[AW-1 -: BW];
        assign wr_bank = AB[AW-1 -: BW];
    end else begin : g_nosel
        assign rd_bank = '0;
        assign wr_bank = '0;
    end

    // No request reaches a bank while reset is held.
    assign a_go = rst_n & ~CENA;
    assign b_go = rst_n & ~CENB;

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        assign rd_req[b] = a_go && (rd_bank == SW'(b));
        assign wr_req[b] = b_go && (wr_bank == SW'(b));

        rf_2p_bank_ret #(
            .BITS        (BITS),
            .ROWS        (ROWS),
            .ROW_W       (RW),
            .IDLE_CYCLES (IDLE_CYCLES),
            .WAKE_CYCLES (WAKE_CYCLES)
        ) u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .rd_req  (rd_req[b]),
            .wr_req  (wr_req[b]),
            .rd_row  (rd_row),
            .wr_row  (wr_row),
            .wr_data (DB),
            .rd_data (rdata[b]),
            .rdy     (bank_rdy[b]),
            .ret_n   (ret_n[b])
        );
    end

    assign RDYA = a_go & bank_rdy[rd_bank];
    assign RDYB = b_go & bank_rdy[wr_bank];

    // Read data register; same-address write wins over the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            QA <= '0;
        end else if (RDYA) begin
            QA <= (RDYB && AA == AB) ? DB : rdata[rd_bank];
        end
    end

    // Access and retention statistics, free-running and wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            ret_cnt <= '0;
        end else begin
            if (RDYA) rd_cnt <= rd_cnt + CNT_W'(1);
            if (RDYB) wr_cnt <= wr_cnt + CNT_W'(1);
            ret_cnt <= ret_cnt + CNT_W'($countones(~ret_n));
        end
    end

endmodule

// File: tb/tb_rf_2p_banked_ret.sv
// Directed bench for rf_2p_banked_ret with default parameters.
// Inputs change on negedge; outputs sampled at negedge+1 or posedge+1.
module tb_rf_2p_banked_ret;

    logic        clk;
    logic        rst_n;
    logic        CENA;
    logic [7:0]  AA;
    logic [31:0] QA;
    logic        RDYA;
    logic        CENB;
    logic [7:0]  AB;
    logic [31:0] DB;
    logic        RDYB;
    logic [3:0]  ret_n;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;
    logic [31:0] ret_cnt;

    int checks;
    int errors;

    rf_2p_banked_ret dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .CENA    (CENA),
        .AA      (AA),
        .QA      (QA),
        .RDYA    (RDYA),
        .CENB    (CENB),
        .AB      (AB),
        .DB      (DB),
        .RDYB    (RDYB),
        .ret_n   (ret_n),
        .rd_cnt  (rd_cnt),
        .wr_cnt  (wr_cnt),
        .ret_cnt (ret_cnt)
    );

    always #5 clk = ~clk;

    task automatic test_reset;
        @(negedge clk);
        rst_n = 0;
        #1;
        checks++;
        if (QA !== 32'h0) begin
            errors++; $display("FAIL rst_qa got %h exp 0", QA);
        end
        checks++;
        if (RDYA !== 1'b0 || RDYB !== 1'b0) begin
            errors++; $display("FAIL rst_rdy got %b%b exp 00", RDYA, RDYB);
        end
        checks++;
        if (ret_n !== 4'hF) begin
            errors++; $display("FAIL rst_ret_n got %b exp 1111", ret_n);
        end
        checks++;
        if (rd_cnt !== 0 || wr_cnt !== 0 || ret_cnt !== 0) begin
            errors++;
            $display("FAIL rst_cnt got %0d %0d %0d exp 0 0 0",
                     rd_cnt, wr_cnt, ret_cnt);
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_write_read;
        @(negedge clk);
        CENB = 0; AB = 8'd5; DB = 32'hDEADBEEF;
        #1;
        checks++;
        if (RDYB !== 1'b1) begin
            errors++; $display("FAIL wr_rdy got %b exp 1", RDYB);
        end
        @(negedge clk);
        AB = 8'h40; DB = 32'hA5A50001;
        CENA = 0; AA = 8'd5;
        #1;
        checks++;
        if (RDYA !== 1'b1) begin
            errors++; $display("FAIL rd_rdy got %b exp 1", RDYA);
        end
        @(posedge clk); #1;
        checks++;
        if (QA !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rd_data got %h exp deadbeef", QA);
        end
        @(negedge clk);
        CENA = 1;
        AB = 8'hC0; DB = 32'hC0C0C0C0;
        @(negedge clk);
        AB = 8'd9; DB = 32'h0;
        @(negedge clk);
        CENB = 1;
        #1;
        checks++;
        if (rd_cnt !== 1 || wr_cnt !== 4) begin
            errors++;
            $display("FAIL wr_rd_cnt got %0d %0d exp 1 4", rd_cnt, wr_cnt);
        end
    endtask

    task automatic test_collision;
        @(negedge clk);
        CENA = 0; AA = 8'd9;
        CENB = 0; AB = 8'd9; DB = 32'h12345678;
        #1;
        checks++;
        if (RDYA !== 1'b1 || RDYB !== 1'b1) begin
            errors++; $display("FAIL col_rdy got %b%b exp 11", RDYA, RDYB);
        end
        @(posedge clk); #1;
        checks++;
        if (QA !== 32'h12345678) begin
            errors++; $display("FAIL col_bypass got %h exp 12345678", QA);
        end
        @(negedge clk);
        CENB = 1;
        @(posedge clk); #1;
        checks++;
        if (QA !== 32'h12345678) begin
            errors++; $display("FAIL col_array got %h exp 12345678", QA);
        end
        @(negedge clk);
        CENA = 1;
        CENB = 0; AB = 8'd9; DB = 32'hFFFF0000;
        @(posedge clk); #1;
        checks++;
        if (QA !== 32'h12345678) begin
            errors++; $display("FAIL qa_hold got %h exp 12345678", QA);
        end
        checks++;
        if (rd_cnt !== 3 || wr_cnt !== 6) begin
            errors++;
            $display("FAIL col_cnt got %0d %0d exp 3 6", rd_cnt, wr_cnt);
        end
        @(negedge clk);
        CENB = 1;
    endtask

    task automatic test_retention;
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        #1;
        checks++;
        if (rd_cnt !== 0 || wr_cnt !== 0) begin
            errors++;
            $display("FAIL ret_rst_cnt got %0d %0d exp 0 0", rd_cnt, wr_cnt);
        end
        repeat (15) @(posedge clk);
        #1;
        checks++;
        if (ret_n !== 4'hF) begin
            errors++; $display("FAIL ret_early got %b exp 1111", ret_n);
        end
        @(posedge clk); #1;
        checks++;
        if (ret_n !== 4'h0) begin
            errors++; $display("FAIL ret_entry got %b exp 0000", ret_n);
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (ret_cnt !== 40) begin
            errors++; $display("FAIL ret_cnt got %0d exp 40", ret_cnt);
        end
    endtask

    task automatic test_wake;
        @(negedge clk);
        CENA = 0; AA = 8'h40;
        #1;
        checks++;
        if (RDYA !== 1'b0 || ret_n !== 4'b0000) begin
            errors++;
            $display("FAIL wake_c0 got rdy %b ret_n %b exp 0 0000", RDYA, ret_n);
        end
        @(negedge clk); #1;
        checks++;
        if (RDYA !== 1'b0 || ret_n !== 4'b0010) begin
            errors++;
            $display("FAIL wake_c1 got rdy %b ret_n %b exp 0 0010", RDYA, ret_n);
        end
        @(negedge clk); #1;
        checks++;
        if (RDYA !== 1'b1) begin
            errors++; $display("FAIL wake_c2 got rdy %b exp 1", RDYA);
        end
        @(posedge clk); #1;
        checks++;
        if (QA !== 32'hA5A50001 || rd_cnt !== 1) begin
            errors++;
            $display("FAIL wake_data got %h cnt %0d exp a5a50001 1", QA, rd_cnt);
        end
        @(negedge clk);
        CENA = 1;
    endtask

    task automatic test_independent;
        @(negedge clk);
        CENB = 0; AB = 8'd7; DB = 32'h0BADF00D;
        #1;
        checks++;
        if (RDYB !== 1'b0) begin
            errors++; $display("FAIL b0wake_c0 got %b exp 0", RDYB);
        end
        @(negedge clk); #1;
        checks++;
        if (RDYB !== 1'b0) begin
            errors++; $display("FAIL b0wake_c1 got %b exp 0", RDYB);
        end
        @(negedge clk); #1;
        checks++;
        if (RDYB !== 1'b1) begin
            errors++; $display("FAIL b0wake_c2 got %b exp 1", RDYB);
        end
        @(negedge clk);
        AB = 8'd3; DB = 32'h11112222;
        CENA = 0; AA = 8'hC0;
        #1;
        checks++;
        if (RDYB !== 1'b1 || RDYA !== 1'b0) begin
            errors++;
            $display("FAIL indep_c0 got b %b a %b exp 1 0", RDYB, RDYA);
        end
        @(posedge clk); #1;
        checks++;
        if (wr_cnt !== 2 || rd_cnt !== 1) begin
            errors++;
            $display("FAIL indep_cnt got wr %0d rd %0d exp 2 1", wr_cnt, rd_cnt);
        end
        @(negedge clk);
        CENB = 1;
        #1;
        checks++;
        if (RDYA !== 1'b0) begin
            errors++; $display("FAIL indep_c1 got %b exp 0", RDYA);
        end
        @(negedge clk); #1;
        checks++;
        if (RDYA !== 1'b1) begin
            errors++; $display("FAIL indep_c2 got %b exp 1", RDYA);
        end
        @(posedge clk); #1;
        checks++;
        if (QA !== 32'hC0C0C0C0 || rd_cnt !== 2) begin
            errors++;
            $display("FAIL indep_data got %h cnt %0d exp c0c0c0c0 2", QA, rd_cnt);
        end
        @(negedge clk);
        AA = 8'd3;
        @(posedge clk); #1;
        checks++;
        if (QA !== 32'h11112222 || rd_cnt !== 3) begin
            errors++;
            $display("FAIL indep_wr got %h cnt %0d exp 11112222 3", QA, rd_cnt);
        end
        @(negedge clk);
        CENA = 1;
    endtask

    task automatic test_shared_wake;
        @(negedge clk);
        CENA = 0; AA = 8'h80;
        CENB = 0; AB = 8'h81; DB = 32'h22223333;
        #1;
        checks++;
        if (RDYA !== 1'b0 || RDYB !== 1'b0) begin
            errors++; $display("FAIL shw_c0 got %b%b exp 00", RDYA, RDYB);
        end
        @(negedge clk); #1;
        checks++;
        if (RDYA !== 1'b0 || RDYB !== 1'b0 || ret_n[2] !== 1'b1) begin
            errors++;
            $display("FAIL shw_c1 got %b%b ret %b exp 00 1", RDYA, RDYB, ret_n[2]);
        end
        @(negedge clk); #1;
        checks++;
        if (RDYA !== 1'b1 || RDYB !== 1'b1) begin
            errors++; $display("FAIL shw_c2 got %b%b exp 11", RDYA, RDYB);
        end
        @(posedge clk); #1;
        checks++;
        if (wr_cnt !== 3 || rd_cnt !== 4) begin
            errors++;
            $display("FAIL shw_cnt got wr %0d rd %0d exp 3 4", wr_cnt, rd_cnt);
        end
        @(negedge clk);
        CENB = 1; AA = 8'h81;
        @(posedge clk); #1;
        checks++;
        if (QA !== 32'h22223333 || rd_cnt !== 5) begin
            errors++;
            $display("FAIL shw_data got %h cnt %0d exp 22223333 5", QA, rd_cnt);
        end
        @(negedge clk);
        CENA = 1;
    endtask

    task automatic test_reset_mid_wake;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (ret_n !== 4'h0) begin
            errors++; $display("FAIL rmw_ret got %b exp 0000", ret_n);
        end
        @(negedge clk);
        CENA = 0; AA = 8'd5;
        @(posedge clk); #1;
        checks++;
        if (ret_n !== 4'b0001 || RDYA !== 1'b0) begin
            errors++;
            $display("FAIL rmw_wake got %b rdy %b exp 0001 0", ret_n, RDYA);
        end
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (QA !== 0 || RDYA !== 1'b0 || ret_n !== 4'hF) begin
            errors++;
            $display("FAIL rmw_async got qa %h rdy %b ret %b exp 0 0 1111",
                     QA, RDYA, ret_n);
        end
        checks++;
        if (rd_cnt !== 0 || wr_cnt !== 0 || ret_cnt !== 0) begin
            errors++;
            $display("FAIL rmw_cnt got %0d %0d %0d exp 0 0 0",
                     rd_cnt, wr_cnt, ret_cnt);
        end
        @(negedge clk);
        CENA = 1;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        CENA = 0; AA = 8'd5;
        #1;
        checks++;
        if (RDYA !== 1'b1) begin
            errors++; $display("FAIL rmw_rdy got %b exp 1", RDYA);
        end
        @(posedge clk); #1;
        checks++;
        if (QA !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rmw_data got %h exp deadbeef", QA);
        end
        @(negedge clk);
        AA = 8'h40;
        @(posedge clk); #1;
        checks++;
        if (QA !== 32'hA5A50001) begin
            errors++; $display("FAIL rmw_data2 got %h exp a5a50001", QA);
        end
        @(negedge clk);
        CENA = 1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clk    = 0;
        rst_n  = 0;
        CENA   = 1;
        CENB   = 1;
        AA     = '0;
        AB     = '0;
        DB     = '0;
        test_reset();
        test_write_read();
        test_collision();
        test_retention();
        test_wake();
        test_independent();
        test_shared_wake();
        test_reset_mid_wake();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
